// File: rtl/if_stage_nb_pkg.sv
// rtl/if_stage_nb_pkg.sv - shared constants, types and helpers for the fetch stage
package if_stage_nb_pkg;

  localparam logic [31:0] RESET_PC_DEF   = 32'hbfc00000;
  localparam logic [31:0] EXC_VECTOR_DEF = 32'hbfc00380;
  localparam int          FS_TO_DS_BUS_WD = 1 + 32 + 32;

  // One buffered fetch result as handed to ID.
  typedef struct packed {
    logic        adel;
    logic [31:0] pc;
    logic [31:0] inst;
  } fs_entry_t;

  // Redirect target selection: exception beats eret beats branch.
  function automatic logic [31:0] redir_target(
    input logic        exc,
    input logic        eret,
    input logic [31:0] epc,
    input logic [31:0] br_target,
    input logic [31:0] exc_vector
  );
    if (exc) begin
      return exc_vector;
    end else if (eret) begin
      return epc;
    end else begin
      return br_target;
    end
  endfunction

endpackage

// File: rtl/if_stage_nb_fifo.sv
// rtl/if_stage_nb_fifo.sv - synchronous FIFO with clear, count and masked head
module fetch_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4,
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_din,
  input  logic             i_pop,
  input  logic             i_clear,
  output logic [WIDTH-1:0] o_head,
  output logic [CW-1:0]    o_count
);

  localparam logic [CW-1:0] FULL = CW'(DEPTH);
  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_rd;
  logic [AW-1:0]    r_wr;
  logic [CW-1:0]    r_count;
  logic             w_do_pop;
  logic             w_do_push;

  // A push into a full FIFO is only legal when the head leaves in the same cycle.
  assign w_do_pop  = i_pop && (r_count != '0);
  assign w_do_push = i_push && ((r_count != FULL) || w_do_pop);

  // Storage array, written only on accepted pushes; never reset.
  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_wr] <= i_din;
    end
  end

  // Pointer and occupancy bookkeeping; clear empties the FIFO in one cycle.
  always_ff @(posedge clk) begin
    if (reset || i_clear) begin
      r_rd    <= '0;
      r_wr    <= '0;
      r_count <= '0;
    end else begin
      if (w_do_push) begin
        r_wr <= (r_wr == LAST) ? '0 : r_wr + 1'b1;
      end
      if (w_do_pop) begin
        r_rd <= (r_rd == LAST) ? '0 : r_rd + 1'b1;
      end
      if (w_do_push && !w_do_pop) begin
        r_count <= r_count + 1'b1;
      end else if (w_do_pop && !w_do_push) begin
        r_count <= r_count - 1'b1;
      end
    end
  end

  // Head reads as zero when empty so downstream sees clean values.
  assign o_head  = (r_count != '0) ? r_mem[r_rd] : '0;
  assign o_count = r_count;

  a_no_overflow: assert property (@(posedge clk) disable iff (reset)
    !(i_push && !i_clear && (r_count == FULL) && !w_do_pop));

endmodule

// File: rtl/if_stage_nb.sv
// rtl/if_stage_nb.sv - non-blocking instruction fetch stage with cancel and buffer
module if_stage_nb
  import if_stage_nb_pkg::*;
#(
  parameter logic [31:0] RESET_PC        = RESET_PC_DEF,
  parameter logic [31:0] EXC_VECTOR      = EXC_VECTOR_DEF,
  parameter int          MAX_OUTSTANDING = 2,
  parameter int          IBUF_DEPTH      = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        redir_exc,
  input  logic        redir_eret,
  input  logic [31:0] epc,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  input  logic        ds_allowin,
  output logic        fs_to_ds_valid,
  output logic [31:0] fs_pc,
  output logic [31:0] fs_inst,
  output logic        fs_adel,
  output logic        inst_sram_req,
  output logic [31:0] inst_sram_addr,
  output logic [3:0]  inst_sram_wen,
  output logic [31:0] inst_sram_wdata,
  input  logic        inst_sram_addr_ok,
  input  logic        inst_sram_data_ok,
  input  logic [31:0] inst_sram_rdata
);

  localparam int OW  = $clog2(MAX_OUTSTANDING + 1);
  localparam int BW  = $clog2(IBUF_DEPTH + 1);
  localparam int CRW = ((OW > BW) ? OW : BW) + 1;
  localparam logic [OW:0]    MAX_OS = (OW + 1)'(MAX_OUTSTANDING);
  localparam logic [CRW-1:0] DEPTH  = CRW'(IBUF_DEPTH);

  logic [31:0]    r_pc;
  logic [OW-1:0]  r_outstanding;
  logic [OW-1:0]  r_cancel_cnt;
  logic           r_adel_done;

  logic           w_redirect;
  logic [31:0]    w_target;
  logic           w_aligned;
  logic           w_credit;
  logic           w_room;
  logic           w_hs;
  logic           w_dok_cancel;
  logic           w_live_ok;
  logic           w_adel_push;
  logic           w_buf_push;
  logic           w_pop;
  fs_entry_t      w_buf_din;
  fs_entry_t      w_buf_head;
  logic [BW-1:0]  w_buf_count;
  logic [31:0]    w_pcq_head;
  logic [OW-1:0]  w_pcq_count;

  assign w_redirect = redir_exc || redir_eret || br_taken;
  assign w_target   = redir_target(redir_exc, redir_eret, epc, br_target, EXC_VECTOR);
  assign w_aligned  = (r_pc[1:0] == 2'b00);

  // Credit reserves a buffer slot for every live request before it is issued.
  assign w_credit = (CRW'(r_outstanding) + CRW'(w_buf_count)) < DEPTH;
  assign w_room   = ({1'b0, r_outstanding} + {1'b0, r_cancel_cnt}) < MAX_OS;

  assign inst_sram_req   = !reset && !w_redirect && w_aligned && w_credit && w_room;
  assign inst_sram_addr  = r_pc;
  assign inst_sram_wen   = 4'h0;
  assign inst_sram_wdata = 32'h0;
  assign w_hs            = inst_sram_req && inst_sram_addr_ok;

  // Responses drain cancelled requests first since they are returned in order.
  assign w_dok_cancel = inst_sram_data_ok && (r_cancel_cnt != '0);
  assign w_live_ok    = inst_sram_data_ok && (r_cancel_cnt == '0) && (w_pcq_count != '0);

  assign w_adel_push = !w_aligned && (r_outstanding == '0) && w_credit
                       && !r_adel_done && !w_redirect;
  assign w_buf_push  = (w_live_ok && !w_redirect) || w_adel_push;
  assign w_buf_din   = w_adel_push ? fs_entry_t'{adel: 1'b1, pc: r_pc, inst: 32'h0}
                                   : fs_entry_t'{adel: 1'b0, pc: w_pcq_head, inst: inst_sram_rdata};
  assign w_pop       = fs_to_ds_valid && ds_allowin && !w_redirect;

  fetch_fifo #(.WIDTH(32), .DEPTH(MAX_OUTSTANDING)) u_pc_q (
    .clk     (clk),
    .reset   (reset),
    .i_push  (w_hs),
    .i_din   (r_pc),
    .i_pop   (w_live_ok),
    .i_clear (w_redirect),
    .o_head  (w_pcq_head),
    .o_count (w_pcq_count)
  );

  fetch_fifo #(.WIDTH(FS_TO_DS_BUS_WD), .DEPTH(IBUF_DEPTH)) u_ibuf (
    .clk     (clk),
    .reset   (reset),
    .i_push  (w_buf_push),
    .i_din   (w_buf_din),
    .i_pop   (w_pop),
    .i_clear (w_redirect),
    .o_head  (w_buf_head),
    .o_count (w_buf_count)
  );

  // PC, live/cancelled request counters and the misaligned-stall flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pc          <= RESET_PC;
      r_outstanding <= '0;
      r_cancel_cnt  <= '0;
      r_adel_done   <= 1'b0;
    end else if (w_redirect) begin
      r_pc          <= w_target;
      r_outstanding <= '0;
      r_cancel_cnt  <= r_cancel_cnt + r_outstanding - OW'(inst_sram_data_ok);
      r_adel_done   <= 1'b0;
    end else begin
      if (w_hs) begin
        r_pc <= r_pc + 32'd4;
      end
      r_outstanding <= r_outstanding + OW'(w_hs) - OW'(w_live_ok);
      r_cancel_cnt  <= r_cancel_cnt - OW'(w_dok_cancel);
      if (w_adel_push) begin
        r_adel_done <= 1'b1;
      end
    end
  end

  assign fs_to_ds_valid = (w_buf_count != '0);
  assign fs_pc          = w_buf_head.pc;
  assign fs_inst        = w_buf_head.inst;
  assign fs_adel        = w_buf_head.adel;

  a_no_stray_data_ok: assert property (@(posedge clk) disable iff (reset)
    inst_sram_data_ok |-> ((r_outstanding != '0) || (r_cancel_cnt != '0)));

endmodule

// File: tb/tb_if_stage_nb.sv
// tb/tb_if_stage_nb.sv - scoreboard testbench for the non-blocking fetch stage
module tb_if_stage_nb;

  localparam int IBUF_DEPTH = 4;
  localparam int MAX_OS     = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        redir_exc, redir_eret, br_taken, ds_allowin;
  logic [31:0] epc, br_target;
  logic        fs_to_ds_valid, fs_adel, inst_sram_req;
  logic [31:0] fs_pc, fs_inst, inst_sram_addr, inst_sram_wdata;
  logic [3:0]  inst_sram_wen;
  logic        inst_sram_addr_ok, inst_sram_data_ok;
  logic [31:0] inst_sram_rdata;

  if_stage_nb dut (
    .clk(clk), .reset(reset), .redir_exc(redir_exc), .redir_eret(redir_eret), .epc(epc),
    .br_taken(br_taken), .br_target(br_target), .ds_allowin(ds_allowin),
    .fs_to_ds_valid(fs_to_ds_valid), .fs_pc(fs_pc), .fs_inst(fs_inst), .fs_adel(fs_adel),
    .inst_sram_req(inst_sram_req), .inst_sram_addr(inst_sram_addr),
    .inst_sram_wen(inst_sram_wen), .inst_sram_wdata(inst_sram_wdata),
    .inst_sram_addr_ok(inst_sram_addr_ok), .inst_sram_data_ok(inst_sram_data_ok),
    .inst_sram_rdata(inst_sram_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    int          ready;
    bit          cancelled;
  } fl_t;

  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;
  int          lat = 1;
  bit          hold = 0;
  logic [31:0] exp_pc;
  bit          adel_pushed;
  fl_t         infl[$];
  logic [64:0] expq[$];
  int          n_hs, n_pop, first_pop_cyc;
  bit          first_pop_seen, first_req_seen;
  logic [31:0] first_pop_pc, first_req_addr;

  function automatic logic [31:0] mem_data(input logic [31:0] a);
    return a ^ 32'h1357_9bdf;
  endfunction

  task automatic mark();
    n_hs = 0; n_pop = 0;
    first_pop_seen = 0; first_req_seen = 0;
    first_pop_pc = 32'h0; first_req_addr = 32'h0; first_pop_cyc = -1;
  endtask

  task automatic model_reset();
    infl.delete(); expq.delete();
    exp_pc = 32'hbfc00000; adel_pushed = 0;
  endtask

  task automatic apply_reset();
    reset = 1'b1; redir_exc = 0; redir_eret = 0; br_taken = 0;
    ds_allowin = 0; inst_sram_addr_ok = 0; inst_sram_data_ok = 0; inst_sram_rdata = 32'h0;
    @(posedge clk); @(negedge clk); #1;
    model_reset();
  endtask

  // One clock of SRAM model + scoreboard; called at a negedge with inputs already set.
  task automatic tick();
    bit red, dok, exp_req, hs, adel_cond;
    int live, bsize;
    fl_t f;
    logic [64:0] head;
    logic [31:0] tgt;
    red = redir_exc || redir_eret || br_taken;
    tgt = redir_exc ? 32'hbfc00380 : (redir_eret ? epc : br_target);
    dok = !hold && (infl.size() != 0) && (cyc >= infl[0].ready);
    inst_sram_data_ok = dok;
    inst_sram_rdata = dok ? mem_data(infl[0].addr) : 32'h0;
    #1;
    live = 0;
    foreach (infl[i]) if (!infl[i].cancelled) live++;
    bsize = expq.size();
    exp_req = !red && (exp_pc[1:0] == 2'b00) && (live + bsize < IBUF_DEPTH) && (infl.size() < MAX_OS);
    adel_cond = !red && (exp_pc[1:0] != 2'b00) && (live == 0) && !adel_pushed && (bsize < IBUF_DEPTH);
    checks++;
    if (inst_sram_req !== exp_req) begin
      failures++;
      $display("FAIL req cyc=%0d got=%b exp=%b", cyc, inst_sram_req, exp_req);
    end
    if (inst_sram_req === 1'b1 && exp_req) begin
      checks++;
      if (inst_sram_addr !== exp_pc) begin
        failures++;
        $display("FAIL req_addr cyc=%0d got=%h exp=%h", cyc, inst_sram_addr, exp_pc);
      end
    end
    checks++;
    if (fs_to_ds_valid !== (bsize != 0)) begin
      failures++;
      $display("FAIL valid cyc=%0d got=%b exp=%b", cyc, fs_to_ds_valid, bsize != 0);
    end
    if (!red && fs_to_ds_valid === 1'b1 && ds_allowin && bsize != 0) begin
      head = {fs_adel, fs_pc, fs_inst};
      checks++;
      if (head !== expq[0]) begin
        failures++;
        $display("FAIL head cyc=%0d got=%h exp=%h", cyc, head, expq[0]);
      end
      if (!first_pop_seen) begin
        first_pop_seen = 1; first_pop_pc = fs_pc; first_pop_cyc = cyc;
      end
      void'(expq.pop_front());
      n_pop++;
    end
    hs = (inst_sram_req === 1'b1) && inst_sram_addr_ok;
    if (dok) begin
      f = infl.pop_front();
      if (!red && !f.cancelled) expq.push_back({1'b0, f.addr, mem_data(f.addr)});
    end
    if (adel_cond) begin
      expq.push_back({1'b1, exp_pc, 32'h0});
      adel_pushed = 1;
    end
    if (red) begin
      foreach (infl[i]) infl[i].cancelled = 1;
      expq.delete();
      exp_pc = tgt;
      adel_pushed = 0;
    end
    if (hs) begin
      infl.push_back('{inst_sram_addr, cyc + lat, red});
      n_hs++;
      if (!first_req_seen) begin
        first_req_seen = 1; first_req_addr = inst_sram_addr;
      end
      if (!red) exp_pc = exp_pc + 32'd4;
    end
    @(posedge clk); @(negedge clk);
    cyc++;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic test_reset();
    apply_reset();
    checks++;
    if ({fs_to_ds_valid, inst_sram_req, fs_adel} !== 3'b000) begin
      failures++;
      $display("FAIL reset_ctrl got=%b exp=000", {fs_to_ds_valid, inst_sram_req, fs_adel});
    end
    checks++;
    if ({fs_pc, fs_inst} !== 64'h0) begin
      failures++;
      $display("FAIL reset_data got=%h exp=0", {fs_pc, fs_inst});
    end
    checks++;
    if ({inst_sram_wen, inst_sram_wdata} !== 36'h0) begin
      failures++;
      $display("FAIL sram_const got=%h exp=0", {inst_sram_wen, inst_sram_wdata});
    end
    reset = 1'b0;
  endtask

  task automatic test_back_to_back();
    int start;
    apply_reset(); reset = 1'b0;
    ds_allowin = 1; inst_sram_addr_ok = 1; lat = 1; hold = 0;
    mark(); start = cyc;
    run(12);
    checks++;
    if (first_pop_pc !== 32'hbfc00000) begin
      failures++;
      $display("FAIL t1_first_pc got=%h exp=bfc00000", first_pop_pc);
    end
    checks++;
    if (first_pop_cyc - start != 2) begin
      failures++;
      $display("FAIL t1_latency got=%0d exp=2", first_pop_cyc - start);
    end
    checks++;
    if (n_pop < 9) begin
      failures++;
      $display("FAIL t1_throughput got=%0d exp>=9", n_pop);
    end
  endtask

  task automatic test_backpressure();
    apply_reset(); reset = 1'b0;
    ds_allowin = 0; inst_sram_addr_ok = 1; lat = 1; hold = 0;
    mark();
    run(10);
    checks++;
    if (n_hs != IBUF_DEPTH) begin
      failures++;
      $display("FAIL t2_accepted got=%0d exp=%0d", n_hs, IBUF_DEPTH);
    end
    #1;
    checks++;
    if (inst_sram_req !== 1'b0) begin
      failures++;
      $display("FAIL t2_req_stalled got=%b exp=0", inst_sram_req);
    end
    ds_allowin = 1;
    mark();
    run(12);
    checks++;
    if (n_pop < 8) begin
      failures++;
      $display("FAIL t2_resume got=%0d exp>=8", n_pop);
    end
  endtask

  task automatic test_eret_cancel();
    apply_reset(); reset = 1'b0;
    ds_allowin = 1; inst_sram_addr_ok = 1; lat = 1; hold = 1;
    run(2);
    checks++;
    if (infl.size() != 2) begin
      failures++;
      $display("FAIL t3_outstanding got=%0d exp=2", infl.size());
    end
    redir_eret = 1; epc = 32'h8000_1000;
    tick();
    redir_eret = 0;
    hold = 0;
    mark();
    run(10);
    checks++;
    if (first_pop_pc !== 32'h8000_1000) begin
      failures++;
      $display("FAIL t3_first_pc got=%h exp=80001000", first_pop_pc);
    end
  endtask

  task automatic test_exc_priority();
    apply_reset(); reset = 1'b0;
    ds_allowin = 1; inst_sram_addr_ok = 1; lat = 1; hold = 0;
    run(4);
    redir_exc = 1; br_taken = 1; br_target = 32'h8000_0040; epc = 32'h8000_2000;
    mark();
    tick();
    redir_exc = 0; br_taken = 0;
    run(8);
    checks++;
    if (first_req_addr !== 32'hbfc00380) begin
      failures++;
      $display("FAIL t4_req_addr got=%h exp=bfc00380", first_req_addr);
    end
    checks++;
    if (first_pop_pc !== 32'hbfc00380) begin
      failures++;
      $display("FAIL t4_first_pc got=%h exp=bfc00380", first_pop_pc);
    end
  endtask

  task automatic test_adel();
    apply_reset(); reset = 1'b0;
    ds_allowin = 1; inst_sram_addr_ok = 1; lat = 2; hold = 0;
    run(3);
    ds_allowin = 0;
    br_taken = 1; br_target = 32'h8000_0002;
    tick();
    br_taken = 0;
    run(6);
    #1;
    checks++;
    if ({fs_to_ds_valid, fs_adel, inst_sram_req} !== 3'b110) begin
      failures++;
      $display("FAIL t5_ctrl got=%b exp=110", {fs_to_ds_valid, fs_adel, inst_sram_req});
    end
    checks++;
    if ({fs_pc, fs_inst} !== {32'h8000_0002, 32'h0}) begin
      failures++;
      $display("FAIL t5_entry got=%h exp=8000000200000000", {fs_pc, fs_inst});
    end
    ds_allowin = 1;
    run(4);
    checks++;
    if (fs_to_ds_valid !== 1'b0) begin
      failures++;
      $display("FAIL t5_stall got=%b exp=0", fs_to_ds_valid);
    end
    lat = 1;
  endtask

  task automatic test_reset_mid();
    apply_reset(); reset = 1'b0;
    ds_allowin = 0; inst_sram_addr_ok = 1; lat = 1; hold = 0;
    run(8);
    checks++;
    if (fs_to_ds_valid !== 1'b1 || expq.size() != IBUF_DEPTH) begin
      failures++;
      $display("FAIL t6_full got=%b/%0d exp=1/%0d", fs_to_ds_valid, expq.size(), IBUF_DEPTH);
    end
    apply_reset();
    checks++;
    if ({fs_to_ds_valid, inst_sram_req, fs_adel, fs_pc, fs_inst} !== 67'h0) begin
      failures++;
      $display("FAIL t6_outputs got=%h exp=0", {fs_to_ds_valid, inst_sram_req, fs_adel, fs_pc, fs_inst});
    end
    reset = 1'b0;
    ds_allowin = 1; inst_sram_addr_ok = 1;
    mark();
    run(4);
    checks++;
    if (first_req_addr !== 32'hbfc00000) begin
      failures++;
      $display("FAIL t6_first_req got=%h exp=bfc00000", first_req_addr);
    end
  endtask

  initial begin
    reset = 1'b1; redir_exc = 0; redir_eret = 0; br_taken = 0; ds_allowin = 0;
    epc = 32'h0; br_target = 32'h0;
    inst_sram_addr_ok = 0; inst_sram_data_ok = 0; inst_sram_rdata = 32'h0;
    model_reset();
    mark();
    @(negedge clk);
    test_reset();
    test_back_to_back();
    test_backpressure();
    test_eret_cancel();
    test_exc_priority();
    test_adel();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
